// File: rtl/mem_stage.sv
// mips789 memory-access stage: registers the exec result, runs the req/ack data-memory handshake,
// formats big-endian store lanes and load data. Optional macro MEM_ALIGN_EXC_EN enables misalignment faults.
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        pause,
    input  logic [31:0] alu_ur_o,
    input  logic [31:0] dmem_data_ur_o,
    input  logic [3:0]  dmem_ctl_i,
    input  logic        wb_we_i,
    input  logic [4:0]  wb_addr_i,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    output logic        dmem_we,
    output logic        dmem_req,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall_o,
    output logic [31:0] fw_dmem,
    output logic [31:0] wb_data_o,
    output logic        wb_we_o,
    output logic [4:0]  wb_addr_o,
    output logic        align_exc_o,
    output logic [31:0] bad_addr_o
);

    localparam logic [3:0] OP_NONE = 4'd0;
    localparam logic [3:0] OP_LW   = 4'd1;
    localparam logic [3:0] OP_LH   = 4'd2;
    localparam logic [3:0] OP_LHU  = 4'd3;
    localparam logic [3:0] OP_LB   = 4'd4;
    localparam logic [3:0] OP_LBU  = 4'd5;
    localparam logic [3:0] OP_SW   = 4'd6;
    localparam logic [3:0] OP_SH   = 4'd7;
    localparam logic [3:0] OP_SB   = 4'd8;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD} state_t;

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_op;
    logic [31:0] r_addr;
    logic [31:0] r_sdata;
    logic        r_wb_we;
    logic [4:0]  r_wb_addr;
    logic [31:0] r_ld;

    logic [3:0]  w_op_in;
    logic        w_load_en;
    logic        w_issue;
    logic        w_is_load;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ld_ext;

    // Undefined op codes collapse to NONE so they never start an access
    assign w_op_in   = (dmem_ctl_i <= OP_SB) ? dmem_ctl_i : OP_NONE;
    assign w_load_en = !pause && !stall_o;
    assign w_is_load = (r_op >= OP_LW) && (r_op <= OP_LBU);

`ifdef MEM_ALIGN_EXC_EN
    logic r_mis;
    logic r_exc;
    logic [31:0] r_bad_addr;
    logic w_mis_in;

    always_comb begin
        w_mis_in = 1'b0;
        case (w_op_in)
            OP_LW, OP_SW:          w_mis_in = |alu_ur_o[1:0];
            OP_LH, OP_LHU, OP_SH:  w_mis_in = alu_ur_o[0];
            default:               w_mis_in = 1'b0;
        endcase
    end

    assign w_issue = (w_op_in != OP_NONE) && !w_mis_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mis      <= 1'b0;
            r_exc      <= 1'b0;
            r_bad_addr <= '0;
        end else begin
            r_exc <= w_load_en && w_mis_in;
            if (w_load_en) begin
                r_mis <= w_mis_in;
                if (w_mis_in)
                    r_bad_addr <= alu_ur_o;
            end
        end
    end

    assign align_exc_o = r_exc;
    assign bad_addr_o  = r_bad_addr;
    assign wb_we_o     = r_wb_we && !stall_o && !r_mis;
`else
    assign w_issue     = (w_op_in != OP_NONE);
    assign align_exc_o = 1'b0;
    assign bad_addr_o  = '0;
    assign wb_we_o     = r_wb_we && !stall_o;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_op      <= OP_NONE;
            r_addr    <= '0;
            r_sdata   <= '0;
            r_wb_we   <= 1'b0;
            r_wb_addr <= '0;
            r_ld      <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load_en) begin
                r_op      <= w_op_in;
                r_addr    <= alu_ur_o;
                r_sdata   <= dmem_data_ur_o;
                r_wb_we   <= wb_we_i;
                r_wb_addr <= wb_addr_i;
            end
            if ((r_state == S_REQ) && dmem_ack && w_is_load)
                r_ld <= w_ld_ext;
        end
    end

    // A new op always wins over the ack path: the ack cycle itself clears the stall
    always_comb begin
        w_state_nxt = r_state;
        if (w_load_en)
            w_state_nxt = w_issue ? S_REQ : S_IDLE;
        else if ((r_state == S_REQ) && dmem_ack)
            w_state_nxt = S_HOLD;
    end

    always_comb begin
        w_byte = r_addr[1] ? (r_addr[0] ? dmem_rdata[7:0]   : dmem_rdata[15:8])
                           : (r_addr[0] ? dmem_rdata[23:16] : dmem_rdata[31:24]);
        w_half = r_addr[1] ? dmem_rdata[15:0] : dmem_rdata[31:16];
        case (r_op)
            OP_LH:   w_ld_ext = {{16{w_half[15]}}, w_half};
            OP_LHU:  w_ld_ext = {16'd0, w_half};
            OP_LB:   w_ld_ext = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  w_ld_ext = {24'd0, w_byte};
            default: w_ld_ext = dmem_rdata;
        endcase
    end

    always_comb begin
        dmem_be    = 4'b0000;
        dmem_wdata = r_sdata;
        case (r_op)
            OP_SH:   dmem_wdata = {2{r_sdata[15:0]}};
            OP_SB:   dmem_wdata = {4{r_sdata[7:0]}};
            default: dmem_wdata = r_sdata;
        endcase
        if (r_state == S_REQ) begin
            case (r_op)
                OP_SH:   dmem_be = r_addr[1] ? 4'b0011 : 4'b1100;
                OP_SB:   dmem_be = 4'b1000 >> r_addr[1:0];
                default: dmem_be = 4'b1111;
            endcase
        end
    end

    assign dmem_req  = (r_state == S_REQ);
    assign dmem_we   = dmem_req && (r_op >= OP_SW) && (r_op <= OP_SB);
    assign dmem_addr = {r_addr[31:2], 2'b00};
    assign stall_o   = dmem_req && !dmem_ack;
    assign fw_dmem   = w_is_load ? r_ld : r_addr;
    assign wb_data_o = fw_dmem;
    assign wb_addr_o = r_wb_addr;

endmodule

// File: tb/tb_mem_stage.sv
// Directed-vector bench for mem_stage; define MEM_ALIGN_EXC_EN to exercise the fault path.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        pause;
    logic [31:0] alu_ur_o;
    logic [31:0] dmem_data_ur_o;
    logic [3:0]  dmem_ctl_i;
    logic        wb_we_i;
    logic [4:0]  wb_addr_i;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_we;
    logic        dmem_req;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        stall_o;
    logic [31:0] fw_dmem;
    logic [31:0] wb_data_o;
    logic        wb_we_o;
    logic [4:0]  wb_addr_o;
    logic        align_exc_o;
    logic [31:0] bad_addr_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_stage u_dut (
        .clk            (clk),
        .rst            (rst),
        .pause          (pause),
        .alu_ur_o       (alu_ur_o),
        .dmem_data_ur_o (dmem_data_ur_o),
        .dmem_ctl_i     (dmem_ctl_i),
        .wb_we_i        (wb_we_i),
        .wb_addr_i      (wb_addr_i),
        .dmem_addr      (dmem_addr),
        .dmem_wdata     (dmem_wdata),
        .dmem_be        (dmem_be),
        .dmem_we        (dmem_we),
        .dmem_req       (dmem_req),
        .dmem_ack       (dmem_ack),
        .dmem_rdata     (dmem_rdata),
        .stall_o        (stall_o),
        .fw_dmem        (fw_dmem),
        .wb_data_o      (wb_data_o),
        .wb_we_o        (wb_we_o),
        .wb_addr_o      (wb_addr_o),
        .align_exc_o    (align_exc_o),
        .bad_addr_o     (bad_addr_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs just after the falling edge, then settle before checks
    task automatic step(input logic [3:0] op, input logic [31:0] a, input logic [31:0] sd,
                        input logic we, input logic [4:0] wa, input logic ak,
                        input logic [31:0] rd, input logic p);
        @(negedge clk);
        dmem_ctl_i     = op;
        alu_ur_o       = a;
        dmem_data_ur_o = sd;
        wb_we_i        = we;
        wb_addr_i      = wa;
        dmem_ack       = ak;
        dmem_rdata     = rd;
        pause          = p;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        pause = 1'b0;
        alu_ur_o = '0;
        dmem_data_ur_o = '0;
        dmem_ctl_i = '0;
        wb_we_i = 1'b0;
        wb_addr_i = '0;
        dmem_ack = 1'b0;
        dmem_rdata = '0;

        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_req", dmem_req, 0);
        chk("rst_stall", stall_o, 0);
        chk("rst_wbwe", wb_we_o, 0);
        chk("rst_wbdata", wb_data_o, 0);
        chk("rst_be", dmem_be, 0);
        chk("rst_addr", dmem_addr, 0);
        chk("rst_exc", align_exc_o, 0);
        chk("rst_bad", bad_addr_o, 0);
        rst = 1'b0;

        // zero-wait SB
        step(8, 32'h1003, 32'hAB, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        chk("sb_req", dmem_req, 1);
        chk("sb_be", dmem_be, 4'b0001);
        chk("sb_wdata", dmem_wdata, 32'hABABABAB);
        chk("sb_we", dmem_we, 1);
        chk("sb_addr", dmem_addr, 32'h1000);
        chk("sb_stall", stall_o, 0);
        chk("sb_wbdata", wb_data_o, 32'h1003);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("sb_after_req", dmem_req, 0);
        chk("sb_after_wbdata", wb_data_o, 0);

        // LB with two wait cycles, ack under pause to hold the result
        step(4, 32'h2001, 0, 1, 5, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("lb_w1_stall", stall_o, 1);
        chk("lb_w1_req", dmem_req, 1);
        chk("lb_w1_wbwe", wb_we_o, 0);
        chk("lb_w1_we", dmem_we, 0);
        chk("lb_w1_be", dmem_be, 4'hF);
        chk("lb_w1_addr", dmem_addr, 32'h2000);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("lb_w2_stall", stall_o, 1);
        step(0, 0, 0, 0, 0, 1, 32'h12F45678, 1);
        chk("lb_ack_stall", stall_o, 0);
        chk("lb_ack_req", dmem_req, 1);
        chk("lb_ack_wbwe", wb_we_o, 1);
        chk("lb_ack_wbaddr", wb_addr_o, 5);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        chk("lb_hold_req", dmem_req, 0);
        chk("lb_data", wb_data_o, 32'hFFFFFFF4);
        chk("lb_hold_wbwe", wb_we_o, 1);
        step(0, 0, 0, 0, 0, 1, 32'hDEADBEEF, 1);
        chk("hold_lateack_req", dmem_req, 0);
        chk("hold_lateack_stall", stall_o, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        chk("hold_ld_kept", wb_data_o, 32'hFFFFFFF4);

        // LBU, same sequence
        step(5, 32'h2001, 0, 1, 5, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("lbu_w1_stall", stall_o, 1);
        chk("lbu_ld_unchanged", fw_dmem, 32'hFFFFFFF4);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("lbu_w2_stall", stall_o, 1);
        step(0, 0, 0, 0, 0, 1, 32'h12F45678, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        chk("lbu_data", wb_data_o, 32'h000000F4);

        // LH and LHU at 0x2002
        step(2, 32'h2002, 0, 1, 7, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 32'h1234ABCD, 1);
        chk("lh_ack_stall", stall_o, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        chk("lh_data", wb_data_o, 32'hFFFFABCD);
        chk("lh_wbaddr", wb_addr_o, 7);
        step(3, 32'h2002, 0, 1, 7, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 32'h1234ABCD, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        chk("lhu_data", wb_data_o, 32'h0000ABCD);

        // SH lane formatting
        step(7, 32'h2002, 32'h1234BEEF, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        chk("sh_be", dmem_be, 4'b0011);
        chk("sh_wdata", dmem_wdata, 32'hBEEFBEEF);

        // LH back-to-back with SW: no idle cycle between requests
        step(2, 32'h2002, 0, 1, 7, 0, 0, 0);
        step(6, 32'h2004, 32'hCAFEF00D, 0, 0, 1, 32'h1234ABCD, 0);
        chk("b2b_ack_req", dmem_req, 1);
        chk("b2b_ack_stall", stall_o, 0);
        chk("b2b_ack_we", dmem_we, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("b2b_sw_req", dmem_req, 1);
        chk("b2b_sw_addr", dmem_addr, 32'h2004);
        chk("b2b_sw_we", dmem_we, 1);
        chk("b2b_sw_wdata", dmem_wdata, 32'hCAFEF00D);
        chk("b2b_sw_be", dmem_be, 4'hF);
        chk("b2b_sw_stall", stall_o, 1);
        chk("b2b_sw_wbdata", wb_data_o, 32'h2004);
        chk("b2b_sw_wbwe", wb_we_o, 0);
        step(0, 0, 0, 0, 0, 1, 0, 1);
        chk("b2b_sw_ack_stall", stall_o, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        chk("b2b_hold_req", dmem_req, 0);

        // Reset during a wait
        step(1, 32'h3000, 0, 1, 9, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("rstmid_stall_before", stall_o, 1);
        rst = 1'b1;
        #1;
        chk("rstmid_req", dmem_req, 0);
        chk("rstmid_stall", stall_o, 0);
        chk("rstmid_wbwe", wb_we_o, 0);
        chk("rstmid_wbdata", wb_data_o, 0);
        chk("rstmid_addr", dmem_addr, 0);
        rst = 1'b0;
        step(0, 0, 0, 0, 0, 1, 32'hFFFFFFFF, 0);
        chk("lateack_wbwe", wb_we_o, 0);
        chk("lateack_req", dmem_req, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("lateack_wbdata", wb_data_o, 0);

        // Aligned LW completes normally
        step(1, 32'h3000, 0, 1, 9, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 32'h11223344, 1);
        chk("lw_req", dmem_req, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        chk("lw_data", wb_data_o, 32'h11223344);
        chk("lw_wbwe", wb_we_o, 1);

        // Misaligned LW
        step(1, 32'h3002, 0, 1, 9, 0, 0, 0);
`ifdef MEM_ALIGN_EXC_EN
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("mis_req", dmem_req, 0);
        chk("mis_exc", align_exc_o, 1);
        chk("mis_bad", bad_addr_o, 32'h3002);
        chk("mis_wbwe", wb_we_o, 0);
        chk("mis_stall", stall_o, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("mis_exc_pulse", align_exc_o, 0);
        chk("mis_bad_held", bad_addr_o, 32'h3002);
`else
        step(0, 0, 0, 0, 0, 1, 32'hA5A5A5A5, 1);
        chk("mis_off_req", dmem_req, 1);
        chk("mis_off_addr", dmem_addr, 32'h3000);
        chk("mis_off_exc", align_exc_o, 0);
        chk("mis_off_bad", bad_addr_o, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        chk("mis_off_data", wb_data_o, 32'hA5A5A5A5);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
